// File: rtl/hamming_secded_codec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hamming_secded_codec
// Purpose  : Parametrised Hamming(K+R,K) encoder/decoder, optional SECDED bit,
//            2-stage valid/ready pipeline with saturating error counters.
// Revision : 1.0  initial release
// ============================================================================
module hamming_secded_codec #(
    parameter int K     = 4,
    parameter int R     = 3,
    parameter int EXT   = 0,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K+R+EXT-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K+R+EXT-1:0]   out_data,
    output logic                 out_corrected,
    output logic                 out_uncorrectable,
    input  logic                 clear_counts,
    output logic [CNT_W-1:0]     corr_count,
    output logic [CNT_W-1:0]     uncorr_count
);

    localparam int               N         = K + R + EXT;
    localparam int               M         = K + R;
    localparam logic             C_EXT     = (EXT != 0);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    generate
        if (((2 ** R) < (M + 1)) || ((2 ** (R - 1)) > M)) begin : g_bad_params
            $error("hamming_secded_codec: R=%0d check bits do not fit K=%0d", R, K);
        end
    endgenerate

    // Data bits occupy the non-power-of-two Hamming positions in ascending order.
    function automatic logic [M-1:0] place_data(input logic [K-1:0] d);
        logic [M-1:0] hw;
        int           k;
        hw = '0;
        k  = 0;
        for (int p = 1; p <= M; p++) begin
            if ((p & (p - 1)) != 0) begin
                hw[p-1] = d[k];
                k++;
            end
        end
        return hw;
    endfunction

    function automatic logic [K-1:0] extract_data(input logic [M-1:0] hw);
        logic [K-1:0] d;
        int           k;
        d = '0;
        k = 0;
        for (int p = 1; p <= M; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = hw[p-1];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [R-1:0] syndrome(input logic [M-1:0] hw);
        logic [R-1:0] s;
        s = '0;
        for (int p = 1; p <= M; p++) begin
            if (hw[p-1]) begin
                s = s ^ R'(p);
            end
        end
        return s;
    endfunction

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [M-1:0]     w_s1_hw;
    logic [R-1:0]     w_s1_syn;
    logic             w_s1_par;

    logic             r_s1_valid;
    logic             r_s1_mode;
    logic [M-1:0]     r_s1_hw;
    logic [R-1:0]     r_s1_syn;
    logic             r_s1_par;

    logic [M-1:0]     w_cw;
    logic [N-1:0]     w_enc;
    logic             w_in_range;
    logic             w_corr;
    logic             w_uncorr;
    logic [M-1:0]     w_fix;
    logic [N-1:0]     w_s2_data;

    logic             r_s2_valid;
    logic [N-1:0]     r_out_data;
    logic             r_out_corr;
    logic             r_out_uncorr;
    logic [CNT_W-1:0] r_corr_count;
    logic [CNT_W-1:0] r_uncorr_count;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // With check bits zeroed, the syndrome of the placed data equals the check bits.
    assign w_s1_hw  = mode ? in_data[M-1:0] : place_data(in_data[K-1:0]);
    assign w_s1_syn = syndrome(w_s1_hw);
    assign w_s1_par = ^in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_hw    <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mode <= mode;
                r_s1_hw   <= w_s1_hw;
                r_s1_syn  <= w_s1_syn;
                r_s1_par  <= w_s1_par;
            end
        end
    end

    always_comb begin
        w_cw = r_s1_hw;
        for (int j = 0; j < R; j++) begin
            w_cw[(1 << j) - 1] = r_s1_syn[j];
        end
        // Without the extension bit the cast drops the parity bit again.
        w_enc      = N'({^w_cw, w_cw});
        w_in_range = (r_s1_syn <= R'(M));
        if (C_EXT) begin
            w_corr   = r_s1_par && w_in_range;
            w_uncorr = (!r_s1_par && (r_s1_syn != '0)) || (r_s1_par && !w_in_range);
        end else begin
            w_corr   = (r_s1_syn != '0) && w_in_range;
            w_uncorr = (r_s1_syn != '0) && !w_in_range;
        end
        w_fix = r_s1_hw;
        for (int p = 1; p <= M; p++) begin
            if (w_corr && (r_s1_syn == R'(p))) begin
                w_fix[p-1] = ~r_s1_hw[p-1];
            end
        end
        w_s2_data = r_s1_mode ? N'(extract_data(w_fix)) : w_enc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid   <= 1'b0;
            r_out_data   <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= w_s2_data;
                r_out_corr   <= r_s1_mode && w_corr;
                r_out_uncorr <= r_s1_mode && w_uncorr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_corr_count   <= '0;
            r_uncorr_count <= '0;
        end else if (clear_counts) begin
            r_corr_count   <= '0;
            r_uncorr_count <= '0;
        end else if (r_s2_valid && out_ready) begin
            if (r_out_corr && (r_corr_count != C_CNT_MAX)) begin
                r_corr_count <= r_corr_count + 1'b1;
            end
            if (r_out_uncorr && (r_uncorr_count != C_CNT_MAX)) begin
                r_uncorr_count <= r_uncorr_count + 1'b1;
            end
        end
    end

    assign in_ready          = w_s1_adv;
    assign out_valid         = r_s2_valid;
    assign out_data          = r_out_data;
    assign out_corrected     = r_out_corr;
    assign out_uncorrectable = r_out_uncorr;
    assign corr_count        = r_corr_count;
    assign uncorr_count      = r_uncorr_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_codec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hamming_secded_codec
// Purpose  : Directed self-checking bench: (7,4) instance with 2-bit counters
//            and an (8,4) SECDED instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_hamming_secded_codec;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic       a_corr, a_uncorr, a_clear;
    logic [6:0] a_in_data, a_out_data;
    logic [1:0] a_corr_count, a_uncorr_count;

    logic       b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic       b_corr, b_uncorr, b_clear;
    logic [7:0] b_in_data, b_out_data;
    logic [7:0] b_corr_count, b_uncorr_count;

    hamming_secded_codec #(.K(4), .R(3), .EXT(0), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_corrected(a_corr), .out_uncorrectable(a_uncorr),
        .clear_counts(a_clear), .corr_count(a_corr_count), .uncorr_count(a_uncorr_count)
    );

    hamming_secded_codec #(.K(4), .R(3), .EXT(1), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_corrected(b_corr), .out_uncorrectable(b_uncorr),
        .clear_counts(b_clear), .corr_count(b_corr_count), .uncorr_count(b_uncorr_count)
    );

    // Single beat through an empty pipeline; returns outputs and latency (-1 on timeout).
    task automatic xfer_a(input logic m, input logic [6:0] d, output logic [6:0] od,
                          output logic oc, output logic ou, output int lat);
        a_mode = m; a_in_data = d; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        od = a_out_data; oc = a_corr; ou = a_uncorr;
        if (!a_out_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic xfer_b(input logic m, input logic [7:0] d, output logic [7:0] od,
                          output logic oc, output logic ou, output int lat);
        b_mode = m; b_in_data = d; b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        od = b_out_data; oc = b_corr; ou = b_uncorr;
        if (!b_out_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_mode = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_clear = 0;
        b_mode = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_clear = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got %b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got %b want 1", a_in_ready); end
        checks++; if (a_out_data !== 7'h00) begin errors++; $display("FAIL reset_a_out_data got %h want 00", a_out_data); end
        checks++; if ({a_corr, a_uncorr} !== 2'b00) begin errors++; $display("FAIL reset_a_flags got %b want 00", {a_corr, a_uncorr}); end
        checks++; if ({a_corr_count, a_uncorr_count} !== 4'h0) begin errors++; $display("FAIL reset_a_counts got %h want 0", {a_corr_count, a_uncorr_count}); end
        checks++; if ({b_out_valid, b_in_ready} !== 2'b01) begin errors++; $display("FAIL reset_b_handshake got %b want 01", {b_out_valid, b_in_ready}); end
        checks++; if ({b_corr_count, b_uncorr_count} !== 16'h0) begin errors++; $display("FAIL reset_b_counts got %h want 0", {b_corr_count, b_uncorr_count}); end
    endtask

    task automatic test_encode();
        logic [6:0] od; logic oc, ou; int lat;
        xfer_a(1'b0, 7'h0B, od, oc, ou, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL enc_latency got %0d want 2", lat); end
        checks++; if (od !== 7'h55) begin errors++; $display("FAIL enc_0B got %h want 55", od); end
        checks++; if ({oc, ou} !== 2'b00) begin errors++; $display("FAIL enc_flags got %b want 00", {oc, ou}); end
        xfer_a(1'b0, 7'h0F, od, oc, ou, lat);
        checks++; if (od !== 7'h7F) begin errors++; $display("FAIL enc_0F got %h want 7f", od); end
        xfer_a(1'b0, 7'h01, od, oc, ou, lat);
        checks++; if (od !== 7'h07) begin errors++; $display("FAIL enc_01 got %h want 07", od); end
        xfer_a(1'b0, 7'h7B, od, oc, ou, lat);
        checks++; if (od !== 7'h55) begin errors++; $display("FAIL enc_upper_ignored got %h want 55", od); end
    endtask

    task automatic test_decode();
        logic [6:0] od; logic oc, ou; int lat;
        xfer_a(1'b1, 7'h45, od, oc, ou, lat);
        checks++; if (od !== 7'h0B) begin errors++; $display("FAIL dec_45 got %h want 0b", od); end
        checks++; if ({oc, ou} !== 2'b10) begin errors++; $display("FAIL dec_45_flags got %b want 10", {oc, ou}); end
        checks++; if (a_corr_count !== 2'd1) begin errors++; $display("FAIL dec_45_count got %0d want 1", a_corr_count); end
        xfer_a(1'b1, 7'h55, od, oc, ou, lat);
        checks++; if ({od, oc, ou} !== {7'h0B, 2'b00}) begin errors++; $display("FAIL dec_clean got %h/%b%b want 0b/00", od, oc, ou); end
        checks++; if (a_corr_count !== 2'd1) begin errors++; $display("FAIL dec_clean_count got %0d want 1", a_corr_count); end
        xfer_a(1'b1, 7'h3F, od, oc, ou, lat);
        checks++; if ({od, oc} !== {7'h0F, 1'b1}) begin errors++; $display("FAIL dec_pos7 got %h/%b want 0f/1", od, oc); end
        checks++; if (a_corr_count !== 2'd2) begin errors++; $display("FAIL dec_pos7_count got %0d want 2", a_corr_count); end
    endtask

    task automatic test_secded();
        logic [7:0] od; logic oc, ou; int lat;
        xfer_b(1'b0, 8'h0B, od, oc, ou, lat);
        checks++; if ({od, oc, ou} !== {8'h55, 2'b00}) begin errors++; $display("FAIL ext_enc_0B got %h/%b%b want 55/00", od, oc, ou); end
        xfer_b(1'b0, 8'h01, od, oc, ou, lat);
        checks++; if (od !== 8'h87) begin errors++; $display("FAIL ext_enc_01 got %h want 87", od); end
        xfer_b(1'b1, 8'hD5, od, oc, ou, lat);
        checks++; if ({od, oc, ou} !== {8'h0B, 2'b10}) begin errors++; $display("FAIL ext_dec_D5 got %h/%b%b want 0b/10", od, oc, ou); end
        checks++; if (b_corr_count !== 8'd1) begin errors++; $display("FAIL ext_corr_count got %0d want 1", b_corr_count); end
        xfer_b(1'b1, 8'h56, od, oc, ou, lat);
        checks++; if ({od, oc, ou} !== {8'h0B, 2'b01}) begin errors++; $display("FAIL ext_dec_56 got %h/%b%b want 0b/01", od, oc, ou); end
        checks++; if (b_uncorr_count !== 8'd1) begin errors++; $display("FAIL ext_uncorr_count got %0d want 1", b_uncorr_count); end
        xfer_b(1'b1, 8'hBF, od, oc, ou, lat);
        checks++; if ({od, oc, ou} !== {8'h0F, 2'b10}) begin errors++; $display("FAIL ext_dec_BF got %h/%b%b want 0f/10", od, oc, ou); end
        xfer_b(1'b1, 8'h55, od, oc, ou, lat);
        checks++; if ({od, oc, ou} !== {8'h0B, 2'b00}) begin errors++; $display("FAIL ext_dec_clean got %h/%b%b want 0b/00", od, oc, ou); end
        checks++; if ({b_corr_count, b_uncorr_count} !== {8'd2, 8'd1}) begin errors++; $display("FAIL ext_counts got %0d/%0d want 2/1", b_corr_count, b_uncorr_count); end
    endtask

    task automatic test_back_to_back();
        logic       bm [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [6:0] bd [4] = '{7'h0B, 7'h45, 7'h01, 7'h7F};
        logic [6:0] ed [4] = '{7'h55, 7'h0B, 7'h07, 7'h0F};
        logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        a_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                checks++;
                if ({a_out_valid, a_out_data, a_corr} !== {1'b1, ed[c-2], ec[c-2]})
                begin errors++; $display("FAIL b2b_beat%0d got %b/%h/%b want 1/%h/%b", c - 2, a_out_valid, a_out_data, a_corr, ed[c-2], ec[c-2]); end
            end
            a_in_valid = (c < 4);
            if (c < 4) begin a_mode = bm[c]; a_in_data = bd[c]; end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [6:0] bd [4] = '{7'h00, 7'h01, 7'h0F, 7'h0B};
        logic [6:0] ed [4] = '{7'h00, 7'h07, 7'h7F, 7'h55};
        logic [6:0] got [4];
        int         got_cyc [4];
        int         idx = 0;
        int         nout = 0;
        logic       fire_in;
        for (int c = 0; c < 16; c++) begin
            a_out_ready = (c >= 6);
            a_in_valid  = (idx < 4);
            a_mode      = 1'b0;
            a_in_data   = bd[idx % 4];
            #1;
            fire_in = a_in_valid && a_in_ready;
            if (a_out_valid && a_out_ready && nout < 4) begin
                got[nout] = a_out_data; got_cyc[nout] = c; nout++;
            end
            if (c == 5) begin
                checks++; if (idx != 2 || a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got %0d/%b want 2/0", idx, a_in_ready); end
                checks++; if ({a_out_valid, a_out_data} !== {1'b1, 7'h00}) begin errors++; $display("FAIL bp_hold got %b/%h want 1/00", a_out_valid, a_out_data); end
            end
            @(posedge clk); #1;
            if (fire_in) idx++;
        end
        a_in_valid = 1'b0;
        checks++; if (nout != 4) begin errors++; $display("FAIL bp_count got %0d want 4", nout); end
        for (int k = 0; k < nout; k++) begin
            checks++;
            if (got[k] !== ed[k] || got_cyc[k] != 6 + k)
            begin errors++; $display("FAIL bp_beat%0d got %h@%0d want %h@%0d", k, got[k], got_cyc[k], ed[k], 6 + k); end
        end
    endtask

    task automatic test_saturation();
        logic [6:0] od; logic oc, ou; int lat;
        a_clear = 1'b1; @(posedge clk); #1; a_clear = 1'b0;
        checks++; if (a_corr_count !== 2'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", a_corr_count); end
        for (int i = 0; i < 5; i++) begin
            xfer_a(1'b1, 7'h45, od, oc, ou, lat);
            if (i == 1) begin
                checks++; if (a_corr_count !== 2'd2) begin errors++; $display("FAIL sat_two got %0d want 2", a_corr_count); end
            end
        end
        checks++; if (a_corr_count !== 2'd3) begin errors++; $display("FAIL sat_five got %0d want 3", a_corr_count); end
        a_clear = 1'b1; @(posedge clk); #1; a_clear = 1'b0;
        a_mode = 1'b1; a_in_data = 7'h45; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1; a_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({a_out_valid, a_corr, a_corr_count} !== {2'b11, 2'd0}) begin errors++; $display("FAIL sat_pre_clear got %b%b/%0d want 11/0", a_out_valid, a_corr, a_corr_count); end
        a_clear = 1'b1; @(posedge clk); #1; a_clear = 1'b0;
        checks++; if ({a_out_valid, a_corr_count} !== {1'b0, 2'd0}) begin errors++; $display("FAIL sat_clear_priority got %b/%0d want 0/0", a_out_valid, a_corr_count); end
    endtask

    task automatic test_reset_inflight();
        logic [6:0] od; logic oc, ou; int lat;
        int stale = 0;
        xfer_a(1'b1, 7'h45, od, oc, ou, lat);
        a_out_ready = 1'b0; a_mode = 1'b0; a_in_valid = 1'b1; a_in_data = 7'h0B;
        @(posedge clk); #1; a_in_data = 7'h01;
        @(posedge clk); #1; a_in_valid = 1'b0;
        checks++; if ({a_out_valid, a_in_ready, a_corr_count} !== {2'b10, 2'd1}) begin errors++; $display("FAIL rst_setup got %b%b/%0d want 10/1", a_out_valid, a_in_ready, a_corr_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({a_out_valid, a_in_ready, a_corr_count} !== {2'b01, 2'd0}) begin errors++; $display("FAIL rst_async got %b%b/%0d want 01/0", a_out_valid, a_in_ready, a_corr_count); end
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (a_out_valid) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale got %0d want 0", stale); end
        checks++; if ({a_corr_count, a_uncorr_count, b_corr_count} !== 12'h0) begin errors++; $display("FAIL rst_counts got %0d/%0d/%0d want 0", a_corr_count, a_uncorr_count, b_corr_count); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_decode();
        test_secded();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
- Parametrised successor to the fixed Hamming(7,4) codec.
- Handles any Hamming(K+R, K) code, with an optional extended overall-parity bit for SECDED.
- Per-beat encode/decode mode select; 2-stage valid/ready pipeline with full backpressure; saturating corrected/uncorrectable error counters.
- Sits between the chip IO shim and downstream logic; also reusable as a memory-protection codec.

Parameters:
- K, 4: data bits per word.
- R, 3: Hamming check bits. Must satisfy 2^R >= K+R+1; elaboration fails otherwise.
- EXT, 0: 1 appends an overall parity bit (SECDED).
- CNT_W, 8: error counter width.
- Derived N = K+R+EXT: codeword width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = encode, 1 = decode; sampled with each accepted input beat
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  N  encode: data in bits [K-1:0], upper bits ignored; decode: received codeword
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts a beat
- out_data  out  N  encode: codeword; decode: corrected data in [K-1:0], upper bits 0
- out_corrected  out  1  decode beat had a single-bit error, now corrected
- out_uncorrectable  out  1  decode beat had a detected, uncorrectable error
- clear_counts  in  1  synchronous clear of both counters
- corr_count  out  CNT_W  saturating count of corrected beats
- uncorr_count  out  CNT_W  saturating count of uncorrectable beats

Behaviour:
- Codeword layout:
  - Codeword bit i holds Hamming position i+1, for positions 1..K+R.
  - Check bit j sits at position 2^j and gives even parity over all positions with bit j set.
  - Data bits fill the non-power-of-two positions in ascending order; data[0] is at position 3.
  - If EXT=1, bit N-1 is even parity over bits [N-2:0].
  - Defaults (K=4, R=3, EXT=0) give the classic 7,4 layout.
- Decode:
  - Syndrome s = XOR of the indices of all set positions 1..K+R.
  - EXT=0: s=0 is clean. 1<=s<=K+R: flip position s, set corrected. s>K+R: set uncorrectable, pass data unmodified.
  - EXT=1, with p = parity of the whole word. s=0, p=0: clean. p=1: single error; flip position s (s=0 means the EXT bit itself, data unaffected), set corrected. s!=0, p=0: double error; set uncorrectable, pass data unmodified. p=1 with s>K+R: set uncorrectable.
  - Corrected and uncorrectable are never both set.
- Encode: both flags are 0.
- Pipeline:
  - S1 registers the syndrome/parity (or check bits) together with the beat and its mode.
  - S2 registers the final out_data and flags.
  - s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
  - Latency is 2 cycles from the in_valid&&in_ready edge to out_valid.
  - Throughput is 1 beat/cycle when out_ready is held high.
  - out_data and flags stay stable while out_valid && !out_ready.
  - No beat is ever dropped or duplicated; order is preserved.
  - A mode change between beats takes effect per beat, with no bubble.
- Counters:
  - Increment on the out_valid&&out_ready cycle when the matching flag is set.
  - Saturate at 2^CNT_W-1.
  - clear_counts has priority over a same-cycle increment; result is 0.
- Reset (asynchronous):
  - out_valid=0, S1 valid=0, out_data=0, flags=0, both counts=0, in_ready=1 after deassertion.
  - Reset asserted mid-operation discards all in-flight beats.

Test Plan:
- K=4, R=3, EXT=0, encode in_data=0x0B: out_data=0x55 two cycles later, flags 0.
- Same config, decode 0x45 (position 5 flipped): out_data=0x0B, out_corrected=1, corr_count=1. Decode 0x55: clean, count unchanged.
- EXT=1 (N=8):
  - Encode 0x0B gives 0x55.
  - Decode 0xD5 (EXT bit flipped) gives data 0x0B, corrected=1.
  - Decode 0x56 (bits 0,1 flipped) gives uncorrectable=1, uncorr_count=1.
- Backpressure: out_ready=0, offer 4 beats back-to-back. Exactly 2 accepted, then in_ready=0. Raise out_ready: beats emerge in order, one per cycle, none lost.
- CNT_W=2: 5 corrected beats leave corr_count=3 (saturated). clear_counts on the same cycle as a corrected output gives corr_count=0.
- Reset asserted with 2 beats in flight: out_valid=0 immediately (asynchronous). After release, no stale beat appears and counters read 0.
